// File: rtl/sram_stream_loader.sv
// Packs a little-endian byte stream into data_width words and writes them to consecutive SRAM addresses.
// Latency: write issued the cycle after a word's last byte is accepted; peak 1 word per (data_width/8 + 1) cycles.
// Backpressure: byte_ready is high only while collecting; the stream is held off during WRITE, DONE and IDLE.
//
// Ports: ldr_clk/ldr_rst_n clock and async active-low reset; ldr_start/ldr_base/ldr_count/ldr_abort load control;
//        byte_data/byte_valid/byte_ready input byte stream; sram_address/sram_data_i/sram_cs/sram_we registered
//        SRAM write port; ldr_busy/ldr_done/ldr_words load status.
module sram_stream_loader #(
  parameter int data_width    = 32,  // must be a multiple of 8
  parameter int address_width = 13,
  parameter int count_width   = 14   // address_width+1 so a full-memory load fits
) (
  input  logic                     ldr_clk,
  input  logic                     ldr_rst_n,
  input  logic                     ldr_start,
  input  logic [address_width-1:0] ldr_base,
  input  logic [count_width-1:0]   ldr_count,
  input  logic                     ldr_abort,
  input  logic [7:0]               byte_data,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic [address_width-1:0] sram_address,
  output logic [data_width-1:0]    sram_data_i,
  output logic                     sram_cs,
  output logic                     sram_we,
  output logic                     ldr_busy,
  output logic                     ldr_done,
  output logic [count_width-1:0]   ldr_words
);

  localparam int bytes_per_word = data_width / 8;
  localparam int idx_width      = (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
  localparam logic [idx_width-1:0] last_idx = idx_width'(bytes_per_word - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [address_width-1:0] addr;
  logic [count_width-1:0]   count;
  logic [idx_width-1:0]     byte_idx;
  logic [data_width-1:0]    part_word;
  logic [data_width-1:0]    word_next;
  logic [count_width-1:0]   words_inc;
  logic                     byte_fire;
  logic                     last_byte;

  // Status outputs are pure decodes of the state register.
  assign byte_ready = (state == COLLECT);
  assign ldr_busy   = (state != IDLE);
  assign ldr_done   = (state == DONE);
  assign byte_fire  = byte_valid & byte_ready;
  assign last_byte  = (byte_idx == last_idx);
  assign words_inc  = ldr_words + 1'b1;

  // Partial word with the incoming byte merged into its lane; used both to
  // update the accumulator and, on the last byte, as the SRAM write data.
  always_comb begin
    word_next = part_word;
    for (int k = 0; k < bytes_per_word; k++) begin
      if (byte_idx == idx_width'(k)) begin
        word_next[8*k +: 8] = byte_data;
      end
    end
  end

  always_ff @(posedge ldr_clk or negedge ldr_rst_n) begin
    if (!ldr_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ldr_start) begin
          state_next = (ldr_count != '0) ? COLLECT : DONE;
        end
      end
      COLLECT: begin
        // Abort wins over a same-cycle handshake: the byte is swallowed.
        if (ldr_abort) begin
          state_next = IDLE;
        end else if (byte_fire && last_byte) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        // The write is already on the bus; abort only suppresses DONE.
        if (ldr_abort) begin
          state_next = IDLE;
        end else if (words_inc == count) begin
          state_next = DONE;
        end else begin
          state_next = COLLECT;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ldr_clk or negedge ldr_rst_n) begin
    if (!ldr_rst_n) begin
      addr         <= '0;
      count        <= '0;
      byte_idx     <= '0;
      part_word    <= '0;
      ldr_words    <= '0;
      sram_address <= '0;
      sram_data_i  <= '0;
      sram_cs      <= 1'b0;
      sram_we      <= 1'b0;
    end else begin
      sram_cs <= 1'b0;
      sram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (ldr_start) begin
            ldr_words <= '0;
            byte_idx  <= '0;
            part_word <= '0;
            if (ldr_count != '0) begin
              addr  <= ldr_base;
              count <= ldr_count;
            end
          end
        end
        COLLECT: begin
          if (ldr_abort) begin
            byte_idx  <= '0;
            part_word <= '0;
          end else if (byte_fire) begin
            part_word <= word_next;
            if (last_byte) begin
              // Write port is loaded here so it is a clean register output
              // during the WRITE cycle and holds afterwards.
              byte_idx     <= '0;
              sram_cs      <= 1'b1;
              sram_we      <= 1'b1;
              sram_address <= addr;
              sram_data_i  <= word_next;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        WRITE: begin
          addr      <= addr + 1'b1;  // wraps naturally at 2^address_width
          ldr_words <= words_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_stream_loader.sv
// Self-checking bench for sram_stream_loader: directed scenarios plus randomized loads
// compared against a word-list model built from base, count and the byte stream.
module tb_sram_stream_loader;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int CW = 14;

  logic          ldr_clk    = 1'b0;
  logic          ldr_rst_n  = 1'b0;
  logic          ldr_start  = 1'b0;
  logic [AW-1:0] ldr_base   = '0;
  logic [CW-1:0] ldr_count  = '0;
  logic          ldr_abort  = 1'b0;
  logic [7:0]    byte_data  = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_data_i;
  logic          sram_cs;
  logic          sram_we;
  logic          ldr_busy;
  logic          ldr_done;
  logic [CW-1:0] ldr_words;

  sram_stream_loader #(.data_width(DW), .address_width(AW), .count_width(CW)) dut (
    .ldr_clk(ldr_clk), .ldr_rst_n(ldr_rst_n), .ldr_start(ldr_start), .ldr_base(ldr_base),
    .ldr_count(ldr_count), .ldr_abort(ldr_abort), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .sram_address(sram_address), .sram_data_i(sram_data_i),
    .sram_cs(sram_cs), .sram_we(sram_we), .ldr_busy(ldr_busy), .ldr_done(ldr_done),
    .ldr_words(ldr_words)
  );

  always #5 ldr_clk = ~ldr_clk;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  wr_t        wr_q[$];
  wr_t        exp_q[$];
  logic [7:0] bq[$];
  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0;

  // Monitor: samples mid-cycle, records every SRAM write and done pulse.
  initial forever begin
    @(negedge ldr_clk);
    cyc++;
    if (sram_cs && sram_we) wr_q.push_back({sram_address, sram_data_i});
    if (ldr_done) begin done_cnt++; done_cyc = cyc; end
    if (ldr_start && !ldr_busy && ldr_rst_n) start_cyc = cyc;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference: word w goes to (base+w) mod 2^AW, bytes little-endian.
  task automatic build_expected(input logic [AW-1:0] base, input int count);
    exp_q.delete();
    for (int w = 0; w < count; w++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'((int'(base) + w) % (1 << AW));
      d = {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]};
      exp_q.push_back({a, d});
    end
  endtask

  task automatic fill_seq(input int n, input int first);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'(first + i));
  endtask

  task automatic start_load(input logic [AW-1:0] base, input int count);
    @(posedge ldr_clk); #1;
    wr_q.delete();
    done_cnt  = 0;
    ldr_base  = base;
    ldr_count = CW'(count);
    ldr_start = 1'b1;
    @(posedge ldr_clk); #1;
    ldr_start = 1'b0;
  endtask

  task automatic drive_bytes(input int lo, input int hi, input int stall_pct);
    int i;
    int n;
    i = lo;
    n = 0;
    while (i < hi && n < 2000) begin
      byte_data  = bq[i];
      byte_valid = ($urandom_range(0, 99) >= stall_pct);
      @(negedge ldr_clk);
      if (byte_valid && byte_ready) i++;
      @(posedge ldr_clk); #1;
      n++;
    end
    byte_valid = 1'b0;
    checks++;
    if (i != hi) begin
      errors++;
      $display("FAIL drive_bytes_timeout sent=%0d required=%0d", i - lo, hi - lo);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (ldr_busy && n < 2000) begin @(posedge ldr_clk); #1; n++; end
    checks++;
    if (ldr_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout busy=%b required=0", name, ldr_busy);
    end
    @(posedge ldr_clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({byte_ready, sram_cs, sram_we, ldr_busy, ldr_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required=00000",
               {byte_ready, sram_cs, sram_we, ldr_busy, ldr_done});
    end
    checks++;
    if ({sram_address, sram_data_i, ldr_words} !== '0) begin
      errors++;
      $display("FAIL reset_data addr=%h data=%h words=%0d required=0", sram_address, sram_data_i, ldr_words);
    end
    @(negedge ldr_clk);
    ldr_rst_n  = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    repeat (6) @(posedge ldr_clk);
    #1;
    byte_valid = 1'b0;
    checks++;
    if (wr_q.size() != 0 || byte_ready !== 1'b0 || ldr_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet writes=%0d ready=%b busy=%b required 0/0/0", wr_q.size(), byte_ready, ldr_busy);
    end
  endtask

  task automatic test_single_word();
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    build_expected(13'h0010, 1);
    start_load(13'h0010, 1);
    drive_bytes(0, 4, 0);
    wait_idle("single");
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL single_write count=%0d first=%h required 1 x %h", wr_q.size(),
               (wr_q.size() > 0) ? wr_q[0] : wr_t'(0), exp_q[0]);
    end
    checks++;
    if (done_cnt != 1 || done_cyc - start_cyc != 6) begin
      errors++;
      $display("FAIL single_done pulses=%0d latency=%0d required 1 pulse latency 6", done_cnt, done_cyc - start_cyc);
    end
    checks++;
    if (ldr_words !== CW'(1)) begin
      errors++;
      $display("FAIL single_words got=%0d required=1", ldr_words);
    end
    checks++;
    if (sram_cs !== 1'b0 || sram_address !== exp_q[0].a || sram_data_i !== exp_q[0].d) begin
      errors++;
      $display("FAIL single_hold cs=%b addr=%h data=%h required 0 %h %h", sram_cs, sram_address,
               sram_data_i, exp_q[0].a, exp_q[0].d);
    end
  endtask

  task automatic test_reset_mid_load();
    fill_seq(4, 8'hC0);
    start_load(13'h0020, 1);
    drive_bytes(0, 2, 0);
    @(negedge ldr_clk);
    ldr_rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, sram_cs, sram_we, ldr_busy, ldr_done, sram_address, sram_data_i, ldr_words} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs ready=%b busy=%b addr=%h data=%h words=%0d required all 0",
               byte_ready, ldr_busy, sram_address, sram_data_i, ldr_words);
    end
    @(negedge ldr_clk);
    ldr_rst_n  = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (8) @(posedge ldr_clk);
    #1;
    byte_valid = 1'b0;
    checks++;
    if (wr_q.size() != 0 || ldr_busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet writes=%0d busy=%b ready=%b required 0/0/0", wr_q.size(), ldr_busy, byte_ready);
    end
  endtask

  task automatic test_multi_stall();
    fill_seq(12, 0);
    build_expected(13'h0100, 3);
    start_load(13'h0100, 3);
    drive_bytes(0, 12, 40);
    wait_idle("multi");
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL multi_count got=%0d required=%0d", wr_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      wr_t g;
      g = (i < wr_q.size()) ? wr_q[i] : wr_t'(0);
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL multi_word%0d got=%h@%h required=%h@%h", i, g.d, g.a, exp_q[i].d, exp_q[i].a);
      end
    end
    checks++;
    if (done_cnt != 1 || ldr_words !== CW'(3)) begin
      errors++;
      $display("FAIL multi_status done=%0d words=%0d required 1 and 3", done_cnt, ldr_words);
    end
  endtask

  task automatic test_wrap();
    fill_seq(8, 8'hA0);
    build_expected(13'h1FFF, 2);
    start_load(13'h1FFF, 2);
    drive_bytes(0, 8, 0);
    wait_idle("wrap");
    checks++;
    if (wr_q.size() != 2) begin
      errors++;
      $display("FAIL wrap_count got=%0d required=2", wr_q.size());
    end
    foreach (exp_q[i]) begin
      wr_t g;
      g = (i < wr_q.size()) ? wr_q[i] : wr_t'(0);
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL wrap_word%0d got=%h@%h required=%h@%h", i, g.d, g.a, exp_q[i].d, exp_q[i].a);
      end
    end
    // Back-to-back stream: start cycle, then 5 cycles per word, then DONE.
    checks++;
    if (done_cnt != 1 || done_cyc - start_cyc != 5 * 2 + 1) begin
      errors++;
      $display("FAIL wrap_latency done=%0d latency=%0d required 1 and %0d", done_cnt, done_cyc - start_cyc, 11);
    end
  endtask

  task automatic test_zero_and_busy_start();
    start_load(13'h0400, 0);
    checks++;
    if (ldr_done !== 1'b1 || ldr_busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_done done=%b busy=%b required 1/1", ldr_done, ldr_busy);
    end
    @(posedge ldr_clk); #1;
    checks++;
    if (ldr_done !== 1'b0 || ldr_busy !== 1'b0 || wr_q.size() != 0 || done_cyc - start_cyc != 1) begin
      errors++;
      $display("FAIL zero_after done=%b busy=%b writes=%0d latency=%0d required 0/0/0/1",
               ldr_done, ldr_busy, wr_q.size(), done_cyc - start_cyc);
    end
    fill_seq(8, 8'h50);
    build_expected(13'h0200, 2);
    start_load(13'h0200, 2);
    drive_bytes(0, 5, 0);
    ldr_start = 1'b1;
    ldr_base  = 13'h0500;
    ldr_count = CW'(1);
    @(posedge ldr_clk); #1;
    ldr_start = 1'b0;
    drive_bytes(5, 8, 20);
    wait_idle("busy_start");
    checks++;
    if (wr_q.size() != 2) begin
      errors++;
      $display("FAIL busy_start_count got=%0d required=2", wr_q.size());
    end
    foreach (exp_q[i]) begin
      wr_t g;
      g = (i < wr_q.size()) ? wr_q[i] : wr_t'(0);
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL busy_start_word%0d got=%h@%h required=%h@%h", i, g.d, g.a, exp_q[i].d, exp_q[i].a);
      end
    end
    checks++;
    if (done_cnt != 1 || ldr_words !== CW'(2)) begin
      errors++;
      $display("FAIL busy_start_status done=%0d words=%0d required 1 and 2", done_cnt, ldr_words);
    end
  endtask

  task automatic test_abort();
    fill_seq(8, 8'h60);
    start_load(13'h0300, 2);
    drive_bytes(0, 3, 0);
    byte_data  = bq[3];
    byte_valid = 1'b1;
    ldr_abort  = 1'b1;
    @(negedge ldr_clk);
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_collect_ready got=%b required=1", byte_ready);
    end
    @(posedge ldr_clk); #1;
    ldr_abort  = 1'b0;
    byte_valid = 1'b0;
    repeat (10) @(posedge ldr_clk);
    #1;
    checks++;
    if (wr_q.size() != 0 || done_cnt != 0 || ldr_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_collect writes=%0d done=%0d busy=%b required 0/0/0", wr_q.size(), done_cnt, ldr_busy);
    end

    fill_seq(8, 8'h70);
    build_expected(13'h0340, 2);
    start_load(13'h0340, 2);
    drive_bytes(0, 4, 30);
    checks++;
    if (sram_cs !== 1'b1) begin
      errors++;
      $display("FAIL abort_write_cs got=%b required=1", sram_cs);
    end
    ldr_abort = 1'b1;
    @(posedge ldr_clk); #1;
    ldr_abort = 1'b0;
    checks++;
    if (ldr_busy !== 1'b0 || ldr_words !== CW'(1)) begin
      errors++;
      $display("FAIL abort_write_state busy=%b words=%0d required 0 and 1", ldr_busy, ldr_words);
    end
    repeat (8) @(posedge ldr_clk);
    #1;
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== exp_q[0] || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_write_result writes=%0d first=%h done=%0d required 1 x %h done 0", wr_q.size(),
               (wr_q.size() > 0) ? wr_q[0] : wr_t'(0), exp_q[0], done_cnt);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      logic [AW-1:0] base;
      int count;
      int stall;
      base  = AW'($urandom_range(0, 8191));
      count = $urandom_range(1, 5);
      stall = $urandom_range(0, 60);
      bq.delete();
      for (int i = 0; i < 4 * count; i++) bq.push_back(8'($urandom));
      build_expected(base, count);
      start_load(base, count);
      drive_bytes(0, 4 * count, stall);
      wait_idle("random");
      checks++;
      if (wr_q.size() != exp_q.size() || done_cnt != 1 || ldr_words !== CW'(count)) begin
        errors++;
        $display("FAIL rand%0d_status writes=%0d done=%0d words=%0d required %0d/1/%0d",
                 t, wr_q.size(), done_cnt, ldr_words, exp_q.size(), count);
      end
      foreach (exp_q[i]) begin
        wr_t g;
        g = (i < wr_q.size()) ? wr_q[i] : wr_t'(0);
        checks++;
        if (g !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d_word%0d got=%h@%h required=%h@%h", t, i, g.d, g.a, exp_q[i].d, exp_q[i].a);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_reset_mid_load();
    test_multi_stall();
    test_wrap();
    test_zero_and_busy_start();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
